// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS tone source.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
//
// Holds the waveform mode encoding, the offset-binary MID/PEAK helpers and the
// quarter-sine table generator. The table generator is evaluated at elaboration
// time only, so its real arithmetic never reaches hardware.
package dds_pkg;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SAW      = 2'd3
    } waveform_mode_e;

    // Amplitude is a 9-bit gain where 256 means unity.
    localparam int AMP_W     = 9;
    localparam logic [AMP_W-1:0] AMP_UNITY = 9'd256;

    // Default-width constants for the 8-bit audio path.
    localparam int MID  = 128;
    localparam int PEAK = 127;

    localparam real PI = 3.14159265358979323846;

    function automatic int sample_mid(input int sample_w);
        return 1 << (sample_w - 1);
    endfunction

    function automatic int sample_peak(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

    // Taylor series for sin(x) over [0, pi/2]; ten terms are far beyond the
    // precision needed to round to any practical sample width.
    function automatic real sin_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Entry k (0..Q) of the quarter-wave table: round(PEAK * sin(pi/2 * k/Q)).
    function automatic int quarter_sine_entry(input int k, input int lut_addr_w,
                                              input int sample_w);
        real q_len;
        real v;
        q_len = real'(1 << (lut_addr_w - 2));
        v     = real'(sample_peak(sample_w)) * sin_series(PI / 2.0 * real'(k) / q_len);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/dds_signal_generator_sine_quarter_rom.sv
// Quarter-wave sine lookup with quadrant folding, producing an offset-binary sample.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of idx.
//
// Ports: idx (LUT_ADDR_W-bit phase index, top 2 bits select the quadrant),
//        raw (SAMPLE_W-bit offset-binary sine sample).
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int LUT_ADDR_W = 7,
    parameter int SAMPLE_W   = 8
) (
    input  logic [LUT_ADDR_W-1:0] idx,
    output logic [SAMPLE_W-1:0]   raw
);

    localparam int KW = LUT_ADDR_W - 2;
    localparam int Q  = 1 << KW;
    localparam logic [SAMPLE_W-1:0] MID_V = SAMPLE_W'(sample_mid(SAMPLE_W));

    // Q+1 entries so that both ends of the quarter (0 and PEAK) are exact.
    logic [SAMPLE_W-1:0] quarter_tbl [0:Q];

    for (genvar k = 0; k <= Q; k++) begin : g_tbl
        assign quarter_tbl[k] = SAMPLE_W'(quarter_sine_entry(k, LUT_ADDR_W, SAMPLE_W));
    end

    logic [1:0]          quadrant;
    logic [KW-1:0]       k_idx;
    logic [KW:0]         tbl_addr;
    logic [SAMPLE_W-1:0] mag;

    always_comb begin
        quadrant = idx[LUT_ADDR_W-1 -: 2];
        k_idx    = idx[KW-1:0];
        // Odd quadrants run the table backwards (Q-k) so the wave descends.
        if (quadrant[0]) begin
            tbl_addr = (KW + 1)'(Q) - {1'b0, k_idx};
        end else begin
            tbl_addr = {1'b0, k_idx};
        end
        mag = quarter_tbl[tbl_addr];
        // Second half-period mirrors below MID.
        if (quadrant[1]) begin
            raw = MID_V - mag;
        end else begin
            raw = MID_V + mag;
        end
    end

endmodule

// File: rtl/dds_signal_generator.sv
// DDS tone source: phase accumulator, waveform shaping and amplitude scaling.
// Latency: sample strobe at edge E -> sampleValid/outputSample after edge E+2.
// Backpressure: none; accepts a sampleEnable every cycle, output holds between pulses.
//
// Ports: inputClock/reset_n (async active-low); sampleEnable strobe; phaseClear
//        (sync clear, wins over sampleEnable); freqWord, mode, amplitude controls;
//        outputSample (offset-binary), sampleValid pulse, periodStart (qualified).
module dds_signal_generator
    import dds_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 7,
    parameter int SAMPLE_W   = 8
) (
    input  logic                inputClock,
    input  logic                reset_n,
    input  logic                sampleEnable,
    input  logic                phaseClear,
    input  logic [PHASE_W-1:0]  freqWord,
    input  logic [1:0]          mode,
    input  logic [AMP_W-1:0]    amplitude,
    output logic [SAMPLE_W-1:0] outputSample,
    output logic                sampleValid,
    output logic                periodStart
);

    localparam logic [SAMPLE_W-1:0] MID_V   = SAMPLE_W'(sample_mid(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] SQ_HI_V = SAMPLE_W'(sample_mid(SAMPLE_W) + sample_peak(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] SQ_LO_V = SAMPLE_W'(sample_mid(SAMPLE_W) - sample_peak(SAMPLE_W));
    // Product of a (SAMPLE_W+1)-bit signed offset and a 10-bit signed gain.
    localparam int PW = SAMPLE_W + 11;

    // ---------------- Stage 0: accumulator and capture ----------------
    logic [PHASE_W-1:0]  acc_q, acc_d;
    logic                wrap_flag_q, wrap_flag_d;
    logic [PHASE_W-1:0]  phase_s1_q, phase_s1_d;
    waveform_mode_e      mode_s1_q, mode_s1_d;
    logic [AMP_W-1:0]    amp_s1_q, amp_s1_d;
    logic                wrap_s1_q, wrap_s1_d;
    logic                vld_s1_q, vld_s1_d;

    logic [PHASE_W:0]    acc_sum;
    logic [AMP_W-1:0]    amp_clamped;

    always_comb begin
        acc_sum     = {1'b0, acc_q} + {1'b0, freqWord};
        amp_clamped = (amplitude > AMP_UNITY) ? AMP_UNITY : amplitude;

        acc_d       = acc_q;
        wrap_flag_d = wrap_flag_q;
        phase_s1_d  = phase_s1_q;
        mode_s1_d   = mode_s1_q;
        amp_s1_d    = amp_s1_q;
        wrap_s1_d   = wrap_s1_q;
        vld_s1_d    = 1'b0;

        if (phaseClear) begin
            // Clearing re-arms wrap so the next captured sample starts a period.
            acc_d       = '0;
            wrap_flag_d = 1'b1;
        end else if (sampleEnable) begin
            phase_s1_d  = acc_q;
            mode_s1_d   = waveform_mode_e'(mode);
            amp_s1_d    = amp_clamped;
            wrap_s1_d   = wrap_flag_q;
            vld_s1_d    = 1'b1;
            acc_d       = acc_sum[PHASE_W-1:0];
            wrap_flag_d = acc_sum[PHASE_W];
        end
    end

    // ---------------- Stage 1: raw waveform ----------------
    logic [SAMPLE_W-1:0] raw_s2_q, raw_s2_d;
    logic [AMP_W-1:0]    amp_s2_q, amp_s2_d;
    logic                wrap_s2_q, wrap_s2_d;
    logic                vld_s2_q, vld_s2_d;

    logic [SAMPLE_W-1:0] sine_raw;
    logic [SAMPLE_W-1:0] tri_s;
    logic [SAMPLE_W-1:0] wave_raw;

    sine_quarter_rom #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .SAMPLE_W   (SAMPLE_W)
    ) u_sine_rom (
        .idx (phase_s1_q[PHASE_W-1 -: LUT_ADDR_W]),
        .raw (sine_raw)
    );

    always_comb begin
        // Triangle uses the bits just below the MSB as a ramp and folds it
        // downwards in the second half-period.
        tri_s = phase_s1_q[PHASE_W-2 -: SAMPLE_W];

        case (mode_s1_q)
            SINE:     wave_raw = sine_raw;
            SQUARE:   wave_raw = phase_s1_q[PHASE_W-1] ? SQ_LO_V : SQ_HI_V;
            TRIANGLE: wave_raw = phase_s1_q[PHASE_W-1] ? ~tri_s : tri_s;
            SAW:      wave_raw = phase_s1_q[PHASE_W-1 -: SAMPLE_W];
            default:  wave_raw = MID_V;
        endcase

        raw_s2_d  = raw_s2_q;
        amp_s2_d  = amp_s2_q;
        wrap_s2_d = wrap_s2_q;
        vld_s2_d  = vld_s1_q;
        if (vld_s1_q) begin
            raw_s2_d  = wave_raw;
            amp_s2_d  = amp_s1_q;
            wrap_s2_d = wrap_s1_q;
        end
    end

    // ---------------- Stage 2: amplitude scaling ----------------
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_vld_q, sample_vld_d;
    logic                period_start_q, period_start_d;

    logic signed [SAMPLE_W:0] diff;
    logic signed [PW-1:0]     diff_w;
    logic signed [PW-1:0]     amp_w;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic signed [PW-1:0]     out_w;

    always_comb begin
        // Work around MID in signed arithmetic; the arithmetic shift floors,
        // and with gain <= 256 the result always fits back in SAMPLE_W bits.
        diff   = $signed({1'b0, raw_s2_q}) - $signed({1'b0, MID_V});
        diff_w = PW'(diff);
        amp_w  = $signed(PW'({1'b0, amp_s2_q}));
        prod   = diff_w * amp_w;
        scaled = prod >>> 8;
        out_w  = scaled + $signed(PW'({1'b0, MID_V}));

        sample_d       = sample_q;
        sample_vld_d   = vld_s2_q;
        period_start_d = vld_s2_q & wrap_s2_q;
        if (vld_s2_q) begin
            sample_d = out_w[SAMPLE_W-1:0];
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q          <= '0;
            wrap_flag_q    <= 1'b1;
            phase_s1_q     <= '0;
            mode_s1_q      <= SINE;
            amp_s1_q       <= '0;
            wrap_s1_q      <= 1'b0;
            vld_s1_q       <= 1'b0;
            raw_s2_q       <= MID_V;
            amp_s2_q       <= '0;
            wrap_s2_q      <= 1'b0;
            vld_s2_q       <= 1'b0;
            sample_q       <= MID_V;
            sample_vld_q   <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            wrap_flag_q    <= wrap_flag_d;
            phase_s1_q     <= phase_s1_d;
            mode_s1_q      <= mode_s1_d;
            amp_s1_q       <= amp_s1_d;
            wrap_s1_q      <= wrap_s1_d;
            vld_s1_q       <= vld_s1_d;
            raw_s2_q       <= raw_s2_d;
            amp_s2_q       <= amp_s2_d;
            wrap_s2_q      <= wrap_s2_d;
            vld_s2_q       <= vld_s2_d;
            sample_q       <= sample_d;
            sample_vld_q   <= sample_vld_d;
            period_start_q <= period_start_d;
        end
    end

    assign outputSample = sample_q;
    assign sampleValid  = sample_vld_q;
    assign periodStart  = period_start_q;

endmodule
